// File: rtl/uart_word_tx.sv
// UART 8N1 transmitter for 32-bit words.
// Each word is sent as four bytes. Every byte is framed as a start bit, eight
// data bits (LSB first) and a stop bit, with no gap between the bytes of a word.
// The words are supplied over a valid/ready handshake in the cpuclk domain.
module uart_word_tx #(
  parameter int unsigned CLKS_PER_BIT = 200,
  parameter bit          MSB_FIRST    = 1'b0
) (
  input  logic        cpuclk,
  input  logic        rst,
  input  logic [31:0] word_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  output logic        tx_o,
  output logic        busy_o,
  output logic        word_done_o,
  output logic [15:0] word_count_o
);

  localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic [15:0] word_count_q, word_count_d;

  logic        accept;
  logic        bit_end;
  logic [7:0]  cur_byte;

  assign accept  = word_valid_i & ready_q;
  assign bit_end = (baud_q == BaudLast);
  // The byte being sent always sits at the outgoing end of the shift register.
  assign cur_byte = MSB_FIRST ? shreg_q[31:24] : shreg_q[7:0];

  // State register
  always_ff @(posedge cpuclk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic with the baud, bit and byte counters, and the shift register
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    unique case (state_q)
      StIdle: begin
        // Clear the counters while idle, so the first bit of a word starts
        // its baud count at zero.
        baud_d     = 16'd0;
        bit_idx_d  = 3'd0;
        byte_idx_d = 2'd0;
        if (accept) begin
          state_d = StStart;
          shreg_d = word_i;
        end
      end
      StStart: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d    = 16'd0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_d     = 16'd0;
          byte_idx_d = byte_idx_q + 2'd1;
          shreg_d    = MSB_FIRST ? {shreg_q[23:0], 8'h00} : {8'h00, shreg_q[31:8]};
          state_d    = (byte_idx_q == 2'd3) ? StIdle : StStart;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: the registered outputs are computed from the next state,
  // so the flops change at the same edge as the state
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
    ready_d      = (state_d == StIdle);
    done_d       = (state_q == StStop) && bit_end && (byte_idx_q == 2'd3);
    word_count_d = word_count_q + {15'd0, done_d};
  end

  // Datapath registers
  always_ff @(posedge cpuclk or posedge rst) begin
    if (rst) begin
      baud_q     <= 16'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      shreg_q    <= 32'd0;
    end else begin
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
    end
  end

  // Output registers; tx is taken only from a flop, so the line cannot glitch
  always_ff @(posedge cpuclk or posedge rst) begin
    if (rst) begin
      tx_q         <= 1'b1;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      word_count_q <= 16'd0;
    end else begin
      tx_q         <= tx_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      word_count_q <= word_count_d;
    end
  end

  assign tx_o         = tx_q;
  assign word_ready_o = ready_q;
  assign word_done_o  = done_q;
  assign word_count_o = word_count_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- UART 8N1 transmitter that serialises 32-bit words onto a single TX line, 4 bytes per word.
- Data direction is CPU to host: the opposite direction from the UART programming path, which carries host to CPU.
- Sits on the cpuclk domain. The CPU or a memory-dump sequencer supplies words over a valid/ready handshake.
- Used to read back memory contents and results over the same serial cable used for programming.

Parameters:
CLKS_PER_BIT, 200, cpuclk cycles per UART bit (23.04 MHz / 115200); legal range 2..65535.
MSB_FIRST, 0, byte order within a word: 0 sends bits [7:0] first, 1 sends bits [31:24] first; bits within a byte are always LSB first.

Ports:
cpuclk  input  1  system clock.
rst  input  1  reset, asynchronous and active-high.
word_i  input  32  word to send; sampled only on the accept cycle.
word_valid_i  input  1  word_i is valid.
word_ready_o  output  1  block can accept a word this cycle (registered).
tx_o  output  1  serial line; idle high (registered).
busy_o  output  1  frame in progress.
word_done_o  output  1  one-cycle pulse when the last stop bit of a word completes.
word_count_o  output  16  number of completed words; wraps modulo 2^16.

Behaviour:
- Reset values: tx_o=1, word_ready_o=0, busy_o=0, word_done_o=0, word_count_o=0, state=IDLE, all counters 0.
  - Asserting rst mid-frame forces tx_o=1 immediately (asynchronous reset).
  - The in-flight word is discarded and is not counted.
- word_ready_o rises at the first cpuclk edge after rst deasserts.
- Accept: occurs on a cpuclk edge where word_valid_i & word_ready_o.
  - word_i is latched into a 32-bit shift register.
  - word_ready_o drops at the same edge.
  - word_valid_i while word_ready_o=0 is ignored, and no data is latched.
- State machine: IDLE -> START -> DATA -> STOP, then START again for the next byte, or IDLE after byte 3.
  - IDLE: tx_o=1, busy_o=0, word_ready_o=1. Accept -> START.
  - START: tx_o=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; a 3-bit bit index counts 0..7.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. The 2-bit byte index then increments.
    - If the byte index was 3: -> IDLE, word_done_o=1 for exactly that cycle, word_count_o+1 at the same edge.
    - Otherwise: -> START of the next byte, with no idle gap between bytes.
- Timing:
  - The start bit of byte 0 appears on tx_o in the cycle after the accept edge.
  - A word occupies exactly 40*CLKS_PER_BIT cycles on tx_o.
  - word_ready_o is 1 in the cycle after the final stop-bit cycle.
  - With word_valid_i held high, consecutive words are separated by exactly 1 idle-high cycle.
- busy_o=1 in every non-IDLE state.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and reloads to 0 on every bit boundary.
  - Bit durations never drift.
  - Clearing the counter at accept is required.
- Byte selection: MSB_FIRST=0 shifts the word right by 8 per byte; MSB_FIRST=1 selects bytes 3,2,1,0.
- word_count_o wraps 0xFFFF -> 0x0000 without any other side effect.
- tx_o must be glitch-free: it is driven from a flop only, never from combinational logic.

Test Plan:
- CLKS_PER_BIT=4, MSB_FIRST=0, send 0x12345678.
  - tx_o must show bytes 0x78, 0x56, 0x34, 0x12, each as start 0, LSB-first data, stop 1.
  - Each bit lasts 4 cycles; 160 cycles total.
  - word_done_o pulses once; word_count_o=1.
- Same word with MSB_FIRST=1 -> byte order on the line is 0x12, 0x34, 0x56, 0x78.
- Hold word_valid_i high with 0xA5A5A5A5 then 0x0000FFFF.
  - Exactly 1 idle-high cycle between the two frames.
  - Second word accepted only when word_ready_o=1; word_count_o=2.
- Assert rst at cycle 50 of a frame (CLKS_PER_BIT=4).
  - tx_o=1 and word_ready_o=0 within the same cycle; word_count_o=0.
  - After release, the next word transmits cleanly from its start bit.
- Toggle word_valid_i with new data during busy -> data ignored, the original frame is unchanged on tx_o.
- Preload word_count_o to 0xFFFF via 65535 words (or force), send one more word -> word_count_o=0x0000, word_done_o pulses.
